// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the read and write pointer controllers.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 3;

  // Binary to Gray conversion on a 32-bit container; callers truncate to
  // their own pointer width, which is safe because upper bits are zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary conversion: each binary bit is the XOR of all Gray bits
  // at or above its position.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded bus crossing clock domains.
// Only one bit changes per source update, so per-bit synchronization is safe.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back capture stages; stage 1 may go metastable, stage 2 settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/read_fifo_ctrl.sv
// Read-side pointer controller of an asynchronous FIFO: owns the binary and
// Gray read pointers, the registered empty flag, the read-data-valid pulse
// for a 1-cycle synchronous memory, and a conservative occupancy count.
module read_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  r_clk_in,
  input  logic                  r_reset_in,
  input  logic                  r_request_in,
  input  logic [ADDR_WIDTH:0]   w_gray_ptr_in,
  output logic [ADDR_WIDTH-1:0] r_addr_out,
  output logic [ADDR_WIDTH:0]   r_gray_ptr_out,
  output logic                  ctrl_empty_out,
  output logic                  r_enable_out,
  output logic                  r_valid_out,
  output logic [ADDR_WIDTH:0]   r_count_out
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_gray;
  logic             r_empty;
  logic             r_valid;

  logic [PTR_W-1:0] w_gray_sync;
  logic [PTR_W-1:0] w_wbin_sync;
  logic [PTR_W-1:0] w_bin_next;
  logic [PTR_W-1:0] w_gray_next;
  logic             w_enable;

  // Write pointer is only ever consumed after two local flops.
  sync_2ff #(
    .WIDTH(PTR_W)
  ) u_wptr_sync (
    .clk (r_clk_in),
    .rst (r_reset_in),
    .d   (w_gray_ptr_in),
    .q   (w_gray_sync)
  );

  // A read is accepted only when the registered flag says data is present.
  assign w_enable = r_request_in & ~r_empty;

  // Next-pointer arithmetic; wraps naturally modulo 2**PTR_W.
  always_comb begin
    w_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, w_enable};
    w_gray_next = PTR_W'(bin2gray(32'(w_bin_next)));
    w_wbin_sync = PTR_W'(gray2bin(32'(w_gray_sync)));
  end

  // Pointer, empty flag and valid-pulse registers; reset forces an empty FIFO
  // and kills any read-data-valid pulse already in flight.
  always_ff @(posedge r_clk_in or posedge r_reset_in) begin
    if (r_reset_in) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      // Comparing the post-read pointer lets empty assert on the same edge
      // that consumes the last entry.
      r_empty <= (w_gray_next == w_gray_sync);
      r_valid <= w_enable;
    end
  end

  assign r_addr_out     = r_bin[ADDR_WIDTH-1:0];
  assign r_gray_ptr_out = r_gray;
  assign ctrl_empty_out = r_empty;
  assign r_enable_out   = w_enable;
  assign r_valid_out    = r_valid;
  // Synced write pointer lags the true one, so this never over-reports.
  assign r_count_out    = w_wbin_sync - r_bin;

endmodule

// File: tb/tb_read_fifo_ctrl.sv
// Directed bench for read_fifo_ctrl with ADDR_WIDTH=3.
module tb_read_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       req;
  logic [3:0] wgray;
  logic [2:0] addr;
  logic [3:0] rgray;
  logic       empty;
  logic       en;
  logic       valid;
  logic [3:0] count;

  int n_checks;
  int n_fail;

  read_fifo_ctrl #(.ADDR_WIDTH(3)) dut (
    .r_clk_in       (clk),
    .r_reset_in     (rst),
    .r_request_in   (req),
    .w_gray_ptr_in  (wgray),
    .r_addr_out     (addr),
    .r_gray_ptr_out (rgray),
    .ctrl_empty_out (empty),
    .r_enable_out   (en),
    .r_valid_out    (valid),
    .r_count_out    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_addr"},  32'(addr),  32'd0);
    chk({tag, "_gray"},  32'(rgray), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  // Gray codes of binary read pointer 0..8
  logic [3:0] gray_tbl [0:8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    gray_tbl[0] = 4'b0000; gray_tbl[1] = 4'b0001; gray_tbl[2] = 4'b0011;
    gray_tbl[3] = 4'b0010; gray_tbl[4] = 4'b0110; gray_tbl[5] = 4'b0111;
    gray_tbl[6] = 4'b0101; gray_tbl[7] = 4'b0100; gray_tbl[8] = 4'b1100;

    // Reset with no clock edge yet
    rst = 1'b1; req = 1'b0; wgray = 4'b0000;
    #2;
    chk_reset_vals("rst0");
    chk("rst0_en", 32'(en), 32'd0);
    step();
    step();

    // Three entries written; visibility latency
    rst = 1'b0;
    wgray = 4'b0010;
    step();
    chk("lat_e1_count", 32'(count), 32'd0);
    chk("lat_e1_empty", 32'(empty), 32'd1);
    step();
    chk("lat_e2_count", 32'(count), 32'd3);
    chk("lat_e2_empty", 32'(empty), 32'd1);
    step();
    chk("lat_e3_empty", 32'(empty), 32'd0);
    chk("lat_e3_en",    32'(en),    32'd0);
    chk("lat_e3_addr",  32'(addr),  32'd0);

    // Drain three entries
    req = 1'b1;
    #1;
    chk("rd0_en",    32'(en),    32'd1);
    chk("rd0_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rd_addr", 32'(addr), 32'(i));
      step();
      chk("rd_valid", 32'(valid), 32'd1);
      chk("rd_gray",  32'(rgray), 32'(gray_tbl[i+1]));
      chk("rd_count", 32'(count), 32'(2 - i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_en",    32'(en),    32'd0);

    // Requests while empty are ignored
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ign_en",    32'(en),    32'd0);
      chk("ign_valid", 32'(valid), 32'd0);
      chk("ign_addr",  32'(addr),  32'd3);
      chk("ign_gray",  32'(rgray), 32'd2);
      chk("ign_empty", 32'(empty), 32'd1);
    end

    // Fresh start, full FIFO of 8, read through wrap
    rst = 1'b1;
    #1;
    chk_reset_vals("rst1");
    wgray = 4'b1100;
    step();
    rst = 1'b0;
    step();
    chk("full_e1_addr", 32'(addr), 32'd0);
    step();
    chk("full_e2_count", 32'(count), 32'd8);
    chk("full_e2_empty", 32'(empty), 32'd1);
    chk("full_e2_addr",  32'(addr),  32'd0);
    step();
    chk("full_e3_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_addr", 32'(addr), 32'(i));
      chk("wrap_en",   32'(en),   32'd1);
      step();
      chk("wrap_gray",  32'(rgray), 32'(gray_tbl[i+1]));
      chk("wrap_count", 32'(count), 32'(7 - i));
    end
    chk("wrap_addr_end",  32'(addr),  32'd0);
    chk("wrap_gray_end",  32'(rgray), 32'b1100);
    chk("wrap_empty_end", 32'(empty), 32'd1);
    chk("wrap_valid_end", 32'(valid), 32'd1);
    step();
    chk("wrap_valid_off", 32'(valid), 32'd0);
    chk("wrap_addr_hold", 32'(addr),  32'd0);

    // Reset pulsed mid-burst between edges
    rst = 1'b1;
    #1;
    rst = 1'b0;
    wgray = 4'b0110;
    step();
    step();
    step();
    chk("mb_empty_pre", 32'(empty), 32'd0);
    step();
    step();
    chk("mb_addr_pre",  32'(addr),  32'd2);
    chk("mb_valid_pre", 32'(valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("mb_rst");
    chk("mb_rst_en", 32'(en), 32'd0);
    step();
    chk("mb_rst_valid_edge", 32'(valid), 32'd0);
    chk("mb_rst_addr_edge",  32'(addr),  32'd0);
    rst = 1'b0;
    step();
    chk("mb_rel_addr",  32'(addr),  32'd0);
    chk("mb_rel_valid", 32'(valid), 32'd0);
    step();
    chk("mb_rel_count", 32'(count), 32'd4);
    step();
    chk("mb_rel_en", 32'(en), 32'd1);
    step();
    chk("mb_rel_addr1", 32'(addr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
